// File: rtl/dsp_pkg.sv
// -----------------------------------------------------------------------------
// dsp_pkg
// Shared definitions for the DSP slice datapath.
//   - DSP_DATA_W   : default B/D datapath width.
//   - OP_PREADD /
//     OP_SUB       : OPMODE bit positions that select the pre-adder and its
//                    subtract mode; the slice top slices opmode with these.
//   - preadd_ctrl_t: packed pre-adder control word carried through the
//                    optional control register.
//   - preadd_op_e  : decoded pre-adder operation.
// -----------------------------------------------------------------------------
package dsp_pkg;

    localparam int unsigned DSP_DATA_W = 18;

    localparam int unsigned OP_PREADD = 4;
    localparam int unsigned OP_SUB    = 6;

    typedef struct packed {
        logic preadd_en;
        logic sub;
    } preadd_ctrl_t;

    typedef enum logic [1:0] {
        PaPass = 2'd0,
        PaAdd  = 2'd1,
        PaSub  = 2'd2
    } preadd_op_e;

    // sub is a don't-care when the pre-adder is disabled.
    function automatic preadd_op_e decode_preadd(preadd_ctrl_t ctrl);
        if (!ctrl.preadd_en) begin
            return PaPass;
        end
        return ctrl.sub ? PaSub : PaAdd;
    endfunction

    // Extract the pre-adder controls from a full OPMODE word.
    function automatic preadd_ctrl_t opmode_to_ctrl(logic [OP_SUB:0] opmode);
        preadd_ctrl_t ctrl;
        ctrl.preadd_en = opmode[OP_PREADD];
        ctrl.sub       = opmode[OP_SUB];
        return ctrl;
    endfunction

endpackage

// File: rtl/pipe_reg.sv
// -----------------------------------------------------------------------------
// pipe_reg
// Optional pipeline register with clock enable and asynchronous active-low
// clear. With EN=0 the register is replaced by a wire and clk/rst_n/ce_i are
// ignored.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears the register to 0
//   ce_i  : clock enable, load on clk rise when high, hold when low
//   d_i   : data in
//   q_o   : registered (EN=1) or direct (EN=0) data out
// -----------------------------------------------------------------------------
module pipe_reg #(
    parameter int unsigned WIDTH = 1,
    parameter bit          EN    = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (EN) begin : g_reg
        logic [WIDTH-1:0] data_d;
        logic [WIDTH-1:0] data_q;

        always_comb begin
            data_d = data_q;
            if (ce_i) begin
                data_d = d_i;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_q <= '0;
            end else begin
                data_q <= data_d;
            end
        end

        assign q_o = data_q;
    end else begin : g_wire
        // Clock, reset and enable have no function in the bypassed form.
        logic unused_ctrl;
        assign unused_ctrl = ^{clk, rst_n, ce_i};

        assign q_o = d_i;
    end

endmodule

// File: rtl/dsp_preadd_stage.sv
// -----------------------------------------------------------------------------
// dsp_preadd_stage
// Registered B pre-adder stage of the DSP slice, fed from the B-input mux.
// Stage 0 optionally registers B, D and the pre-adder controls in parallel;
// the combinational pre-adder produces D+B, D-B or B; stage 1 optionally
// registers the result, which drives the multiplier operand and the cascade.
// A valid tag travels alongside B through both stages on the B clock enables
// so it stays aligned with b_out through stalls.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   b_in, d_in           : B word and D operand
//   preadd_en, sub       : 0x -> pass B, 10 -> D+B, 11 -> D-B
//   valid_in             : sample tag for b_in/d_in
//   ce_b0, ce_d, ce_op   : stage-0 enables (B0 + valid0, D, controls)
//   ce_b1                : stage-1 enable (B1 + valid1)
//   b_out, bcout         : multiplier B operand and identical cascade copy
//   valid_out            : tag aligned with b_out
// -----------------------------------------------------------------------------
module dsp_preadd_stage
    import dsp_pkg::*;
#(
    parameter int unsigned WIDTH = DSP_DATA_W,
    parameter bit          B0REG = 1'b1,
    parameter bit          DREG  = 1'b1,
    parameter bit          OPREG = 1'b1,
    parameter bit          B1REG = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] d_in,
    input  logic             preadd_en,
    input  logic             sub,
    input  logic             valid_in,
    input  logic             ce_b0,
    input  logic             ce_d,
    input  logic             ce_op,
    input  logic             ce_b1,
    output logic [WIDTH-1:0] b_out,
    output logic [WIDTH-1:0] bcout,
    output logic             valid_out
);

    // ---------------------------------------------------------------------
    // Stage 0
    // ---------------------------------------------------------------------
    logic [WIDTH-1:0] b0;
    logic [WIDTH-1:0] d0;
    preadd_ctrl_t     ctrl_in;
    preadd_ctrl_t     ctrl0;
    logic             v0;

    assign ctrl_in.preadd_en = preadd_en;
    assign ctrl_in.sub       = sub;

    pipe_reg #(
        .WIDTH (WIDTH),
        .EN    (B0REG)
    ) u_b0_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .ce_i  (ce_b0),
        .d_i   (b_in),
        .q_o   (b0)
    );

    pipe_reg #(
        .WIDTH (WIDTH),
        .EN    (DREG)
    ) u_d_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .ce_i  (ce_d),
        .d_i   (d_in),
        .q_o   (d0)
    );

    // Controls captured on the same edge as B/D apply to that sample.
    pipe_reg #(
        .WIDTH ($bits(preadd_ctrl_t)),
        .EN    (OPREG)
    ) u_op_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .ce_i  (ce_op),
        .d_i   (ctrl_in),
        .q_o   (ctrl0)
    );

    // The tag follows B, so it shares the B0 enable rather than a CE of its own.
    pipe_reg #(
        .WIDTH (1),
        .EN    (B0REG)
    ) u_v0_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .ce_i  (ce_b0),
        .d_i   (valid_in),
        .q_o   (v0)
    );

    // ---------------------------------------------------------------------
    // Pre-adder: unsigned modulo 2^WIDTH, carry and borrow are dropped.
    // ---------------------------------------------------------------------
    logic [WIDTH-1:0] pa;

    always_comb begin
        pa = b0;
        unique case (decode_preadd(ctrl0))
            PaAdd:   pa = d0 + b0;
            PaSub:   pa = d0 - b0;
            default: pa = b0;
        endcase
    end

    // ---------------------------------------------------------------------
    // Stage 1
    // ---------------------------------------------------------------------
    logic [WIDTH-1:0] b1;
    logic             v1;

    pipe_reg #(
        .WIDTH (WIDTH),
        .EN    (B1REG)
    ) u_b1_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .ce_i  (ce_b1),
        .d_i   (pa),
        .q_o   (b1)
    );

    pipe_reg #(
        .WIDTH (1),
        .EN    (B1REG)
    ) u_v1_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .ce_i  (ce_b1),
        .d_i   (v0),
        .q_o   (v1)
    );

    assign b_out     = b1;
    assign bcout     = b1;
    assign valid_out = v1;

endmodule
